// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS fetch-stage sequencer.
//   pc_state_t    : fetch FSM state encoding
//   RESET_PC_DFLT : default PC loaded on reset
//   PC_INC        : sequential PC increment in bytes
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        REDIR = 2'd3
    } pc_state_t;

    localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
    localparam int          PC_INC        = 4;

endpackage

// File: rtl/next_pc_mux.sv
// next_pc_mux: combinational redirect-target computation and priority select.
// Priority: jr (when PC_SEQ_JR_EN is defined) > jump > branch_taken.
// Ports:
//   branch_pc4_i        PC+4 of the branch/jump instruction
//   branch_offset_sl2_i word-aligned sign-extended branch offset
//   branch_taken_i      resolved branch outcome
//   jump_i, jump_index_i J/JAL decision and instr[25:0]
//   jr_i, jr_target_i   jump-register request and target (PC_SEQ_JR_EN only)
//   redirect_o          any redirect requested this cycle
//   target_o            selected redirect target
//   jr_misalign_o       jr requested with a non-word-aligned target (PC_SEQ_JR_EN only)
module next_pc_mux
    import mips_pkg::*;
#(
    parameter int PC_W = 32
)(
    input  logic [PC_W-1:0] branch_pc4_i,
    input  logic [PC_W-1:0] branch_offset_sl2_i,
    input  logic            branch_taken_i,
    input  logic            jump_i,
    input  logic [25:0]     jump_index_i,
`ifdef PC_SEQ_JR_EN
    input  logic            jr_i,
    input  logic [PC_W-1:0] jr_target_i,
    output logic            jr_misalign_o,
`endif
    output logic            redirect_o,
    output logic [PC_W-1:0] target_o
);

    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] jump_target;

    // Carry out of the add is dropped on purpose; wrap-around is a legal target.
    assign branch_target = branch_pc4_i + branch_offset_sl2_i;
    assign jump_target   = {branch_pc4_i[PC_W-1:28], jump_index_i, 2'b00};

    always_comb begin
        redirect_o = 1'b0;
        target_o   = branch_target;
`ifdef PC_SEQ_JR_EN
        jr_misalign_o = 1'b0;
        if (jr_i) begin
            redirect_o    = 1'b1;
            target_o      = {jr_target_i[PC_W-1:2], 2'b00};
            jr_misalign_o = |jr_target_i[1:0];
        end else
`endif
        if (jump_i) begin
            redirect_o = 1'b1;
            target_o   = jump_target;
        end else if (branch_taken_i) begin
            redirect_o = 1'b1;
            target_o   = branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter register and fetch sequencer for the MIPS IF stage.
// Optional jump-register support is enabled by defining PC_SEQ_JR_EN.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   stall               decode hazard stall; holds pc and fetch_valid
//   imem_ready          instruction memory returns data for pc this cycle
//   branch_taken        resolved branch outcome
//   branch_pc4          PC+4 of the branch/jump instruction
//   branch_offset_sl2   sign-extended immediate shifted left by 2
//   jump, jump_index    J/JAL decision and instr[25:0]
//   jr, jr_target       jump-register request and target (PC_SEQ_JR_EN only)
//   pc, pc_plus4        current fetch address and its sequential successor
//   fetch_req           fetch request to instruction memory
//   fetch_valid         IF/ID holds a valid instruction
//   flush               one-cycle squash of younger instructions
//   misalign            one-cycle pulse on a misaligned jr (PC_SEQ_JR_EN only)
//
// state | meaning
// BOOT  | first cycle out of reset, no fetch, redirects ignored
// FETCH | fetching pc, advance when memory is ready
// WAIT  | fetching pc, memory was not ready last cycle
// REDIR | one bubble cycle after a redirect, no fetch
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int            PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DFLT
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_pc4,
    input  logic [PC_W-1:0] branch_offset_sl2,
    input  logic            jump,
    input  logic [25:0]     jump_index,
`ifdef PC_SEQ_JR_EN
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    output logic            misalign,
`endif
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            fetch_req,
    output logic            fetch_valid,
    output logic            flush
);

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            flush_q, flush_d;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
`ifdef PC_SEQ_JR_EN
    logic            jr_misalign;
    logic            misalign_q, misalign_d;
`endif

    next_pc_mux #(.PC_W(PC_W)) u_next_pc_mux (
        .branch_pc4_i        (branch_pc4),
        .branch_offset_sl2_i (branch_offset_sl2),
        .branch_taken_i      (branch_taken),
        .jump_i              (jump),
        .jump_index_i        (jump_index),
`ifdef PC_SEQ_JR_EN
        .jr_i                (jr),
        .jr_target_i         (jr_target),
        .jr_misalign_o       (jr_misalign),
`endif
        .redirect_o          (redirect),
        .target_o            (redirect_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
`ifdef PC_SEQ_JR_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
`ifdef PC_SEQ_JR_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;
`ifdef PC_SEQ_JR_EN
        misalign_d    = 1'b0;
`endif
        // A redirect outranks stall and memory readiness in every state but BOOT.
        if (redirect && (state_q != BOOT)) begin
            state_d       = REDIR;
            pc_d          = redirect_pc;
            fetch_valid_d = 1'b0;
            flush_d       = 1'b1;
`ifdef PC_SEQ_JR_EN
            misalign_d    = jr_misalign;
`endif
        end else begin
            case (state_q)
                BOOT:  state_d = FETCH;
                FETCH, WAIT: begin
                    if (!stall) begin
                        if (imem_ready) begin
                            state_d       = FETCH;
                            pc_d          = pc_plus4;
                            fetch_valid_d = 1'b1;
                        end else begin
                            state_d       = WAIT;
                            fetch_valid_d = 1'b0;
                        end
                    end
                end
                REDIR: state_d = FETCH;
                default: state_d = BOOT;
            endcase
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_W'(PC_INC);
    assign fetch_req   = (state_q == FETCH) || (state_q == WAIT);
    assign fetch_valid = fetch_valid_q;
    assign flush       = flush_q;
`ifdef PC_SEQ_JR_EN
    assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_pc4;
    logic [31:0] branch_offset_sl2;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_req;
    logic        fetch_valid;
    logic        flush;
`ifdef PC_SEQ_JR_EN
    logic        jr;
    logic [31:0] jr_target;
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .imem_ready        (imem_ready),
        .branch_taken      (branch_taken),
        .branch_pc4        (branch_pc4),
        .branch_offset_sl2 (branch_offset_sl2),
        .jump              (jump),
        .jump_index        (jump_index),
`ifdef PC_SEQ_JR_EN
        .jr                (jr),
        .jr_target         (jr_target),
        .misalign          (misalign),
`endif
        .pc                (pc),
        .pc_plus4          (pc_plus4),
        .fetch_req         (fetch_req),
        .fetch_valid       (fetch_valid),
        .flush             (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        bt;
        logic [31:0] bpc4;
        logic [31:0] off;
        logic        jump;
        logic [25:0] ji;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_fv;
        logic        e_fl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic b, input logic [31:0] p4,
                       input logic [31:0] o, input logic j, input logic [25:0] ji,
                       input logic [31:0] epc, input logic ereq, input logic efv, input logic efl);
        vec_t v;
        v.stall = s; v.ready = r; v.bt = b; v.bpc4 = p4; v.off = o; v.jump = j; v.ji = ji;
        v.e_pc = epc; v.e_req = ereq; v.e_fv = efv; v.e_fl = efl;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic s, input logic r, input logic b, input logic [31:0] p4,
                         input logic [31:0] o, input logic j, input logic [25:0] ji);
        stall = s; imem_ready = r; branch_taken = b; branch_pc4 = p4;
        branch_offset_sl2 = o; jump = j; jump_index = ji;
`ifdef PC_SEQ_JR_EN
        jr = 1'b0; jr_target = 32'h0;
`endif
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] epc, input logic ereq,
                           input logic efv, input logic efl);
        chk({tag, ".pc"}, pc, epc);
        chk({tag, ".pc_plus4"}, pc_plus4, epc + 32'd4);
        chk({tag, ".fetch_req"}, {31'b0, fetch_req}, {31'b0, ereq});
        chk({tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, efv});
        chk({tag, ".flush"}, {31'b0, flush}, {31'b0, efl});
    endtask

    initial begin
        // stall ready bt bpc4 off jump ji | pc req fv fl
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0000,1,0,0); // BOOT -> FETCH
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0004,1,1,0);
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0008,1,1,0);
        add(0,0,0,32'h0,32'h0,0,26'h0,           32'h0000_0008,1,0,0); // WAIT
        add(0,0,0,32'h0,32'h0,0,26'h0,           32'h0000_0008,1,0,0);
        add(0,0,0,32'h0,32'h0,0,26'h0,           32'h0000_0008,1,0,0);
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_000C,1,1,0);
        add(0,1,1,32'h20,32'hFFFF_FFF0,0,26'h0,  32'h0000_0010,0,0,1); // backward branch
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0010,1,0,0); // REDIR -> FETCH
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0014,1,1,0);
        add(0,1,1,32'h4000_0010,32'h40,1,26'h100,32'h4000_0400,0,0,1); // jump beats branch
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h4000_0400,1,0,0);
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h4000_0404,1,1,0);
        add(1,1,1,32'h100,32'h8,0,26'h0,         32'h0000_0108,0,0,1); // redirect beats stall
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0108,1,0,0);
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_010C,1,1,0);
        add(1,1,0,32'h0,32'h0,0,26'h0,           32'h0000_010C,1,1,0); // stall holds
        add(1,1,0,32'h0,32'h0,0,26'h0,           32'h0000_010C,1,1,0);
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0110,1,1,0);
        add(0,1,1,32'hFFFF_FFF0,32'h20,0,26'h0,  32'h0000_0010,0,0,1); // target wraps
        add(0,1,1,32'h200,32'h0,0,26'h0,         32'h0000_0200,0,0,1); // redirect in REDIR
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0200,1,0,0);
        add(0,1,0,32'hF000_0000,32'h0,1,26'h3FF_FFFF,32'hFFFF_FFFC,0,0,1);
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'hFFFF_FFFC,1,0,0);
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0000,1,1,0); // pc wraps to 0
        add(0,0,0,32'h0,32'h0,0,26'h0,           32'h0000_0000,1,0,0); // WAIT
        add(1,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0000,1,0,0); // stall in WAIT holds
        add(0,1,0,32'h0,32'h0,0,26'h0,           32'h0000_0004,1,1,0);

        reset = 1'b1;
        drive(0,1,0,32'h0,32'h0,0,26'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk_all("release", 32'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].ready, vecs[i].bt, vecs[i].bpc4,
                  vecs[i].off, vecs[i].jump, vecs[i].ji);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_req,
                    vecs[i].e_fv, vecs[i].e_fl);
        end

        // Asynchronous reset while in REDIR.
        drive(0,1,1,32'h80,32'h0,0,26'h0);
        @(posedge clk);
        #1;
        chk_all("redir_pre_reset", 32'h80, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        // Redirect held across release: BOOT must ignore it.
        @(posedge clk);
        #1;
        chk_all("boot_ignores_redirect", 32'h0, 1'b1, 1'b0, 1'b0);

`ifdef PC_SEQ_JR_EN
        drive(0,1,1,32'h4000_0010,32'h0,1,26'h100);
        jr = 1'b1;
        jr_target = 32'h0000_0103;
        @(posedge clk);
        #1;
        chk_all("jr_redirect", 32'h100, 1'b0, 1'b0, 1'b1);
        chk("jr_misalign_pulse", {31'b0, misalign}, 32'd1);
        drive(0,1,0,32'h0,32'h0,0,26'h0);
        @(posedge clk);
        #1;
        chk_all("jr_after", 32'h100, 1'b1, 1'b0, 1'b0);
        chk("jr_misalign_clear", {31'b0, misalign}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and next-PC selector for the MIPS fetch stage.
- Consumes the word-aligned branch offset produced by the shift-left-by-2 stage, plus the jump index, branch and jump decisions from decode/execute.
- Holds the PC, requests instruction fetches and signals flushes on control-flow redirects.
- Sits directly downstream of shiftLeft2 and upstream of instruction memory and the IF/ID register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, PC and address datapath width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard stall from decode; hold PC and fetch_valid.
- imem_ready  input  1  instruction memory has data for the current pc this cycle.
- branch_taken  input  1  resolved branch outcome.
- branch_pc4  input  32  PC+4 of the branch or jump instruction.
- branch_offset_sl2  input  32  sign-extended immediate already shifted left by 2.
- jump  input  1  J/JAL decoded.
- jump_index  input  26  instr[25:0].
- pc  output  32  current fetch address.
- pc_plus4  output  32  pc + 4, combinational.
- fetch_req  output  1  fetch request to instruction memory.
- fetch_valid  output  1  IF/ID holds a valid instruction.
- flush  output  1  one-cycle squash of younger instructions.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - pc = RESET_PC
  - state = BOOT
  - fetch_valid = 0
  - flush = 0
  - fetch_req = 0
- States:
  - BOOT: fetch_req=0; goes to FETCH on the next edge.
  - FETCH: fetch_req=1.
  - WAIT: fetch_req=1; memory not ready.
  - REDIR: fetch_req=0; one bubble cycle after a redirect.
- Target arithmetic:
  - branch_target = branch_pc4 + branch_offset_sl2, modulo 2^32; the carry is dropped, so wrap-around is legal.
  - jump_target = {branch_pc4[31:28], jump_index, 2'b00}.
  - pc_plus4 wraps from 32'hFFFF_FFFC to 0.
- Redirect priority: jump > branch_taken > sequential. redirect = jump | branch_taken.
- Redirect handling:
  - redirect is honoured in every state except BOOT, regardless of stall and imem_ready. Redirect beats stall.
  - On that edge: pc <= selected target, flush <= 1 for exactly one cycle, fetch_valid <= 0, state <= REDIR.
  - REDIR -> FETCH on the next edge. flush drops to 0 there unless a new redirect arrives.
- FETCH / WAIT with no redirect:
  - stall=1: pc, fetch_valid and state all hold.
  - stall=0, imem_ready=1: pc <= pc_plus4, fetch_valid <= 1, state <= FETCH.
  - stall=0, imem_ready=0: pc holds, fetch_valid <= 0, state <= WAIT.
- Latency: sequential advance costs 1 cycle per instruction. A redirect costs 2 cycles (REDIR bubble + refetch).
- Reset asserted mid-operation: immediate return to reset values; any pending redirect is discarded.

Optional Feature:
- Macro: PC_SEQ_JR_EN.
- With PC_SEQ_JR_EN defined:
  - Adds ports jr (input 1) and jr_target (input 32).
  - Priority becomes jr > jump > branch_taken > sequential.
  - jr_target[1:0] is forced to 2'b00.
  - Adds output misalign (1): a one-cycle pulse when an honoured jr has jr_target[1:0] != 0.
- Without it: none of these ports exist; jump-register is unsupported.

Decomposition:
- Shared package mips_pkg:
  - pc_state_t encoding (BOOT=2'd0, FETCH=2'd1, WAIT=2'd2, REDIR=2'd3).
  - RESET_PC default.
  - PC_INC = 4.
- Sub-module next_pc_mux: combinational target computation and priority selection. The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset, release, imem_ready=1 held: pc = 0, 0, 4, 8. fetch_req rises one cycle after release; fetch_valid=1 from the first advance.
- imem_ready=0 for 3 cycles at pc=8: pc holds 8, state WAIT, fetch_valid=0. On ready, pc becomes 12.
- branch_taken=1, branch_pc4=0x20, branch_offset_sl2=0xFFFF_FFF0 (-16): pc=0x10 next cycle, flush pulses 1 cycle, one bubble, then 0x14.
- jump=1 with branch_taken=1, branch_pc4=0x4000_0010, jump_index=0x0000100: pc=0x4000_0400 (jump wins).
- stall=1 and branch_taken=1 in the same cycle: redirect taken, flush=1. stall alone for 2 cycles: pc and fetch_valid frozen.
- reset asserted asynchronously mid-REDIR: pc=RESET_PC, flush=0 immediately without waiting for a clock edge. With PC_SEQ_JR_EN, jr_target=0x103 gives pc=0x100 and misalign pulses.
